result_capture: RTL and testbench
=================================

RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 Parameter DEPTH, 4, number of FIFO entries (power of two, at least 2).
REQ-002 Parameter CNT_W, 32, width of the cycle counter and rd_cycles.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high. Ports are named CLK and RST.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 in_data  input  16  operand currently applied to the Processor.
REQ-007 out_result  input  16  result bus driven by the Processor.
REQ-008 rd_ready  input  1  consumer accepts the head entry this cycle.
REQ-009 rd_valid  output  1  FIFO is non-empty; the head entry is presented.
REQ-010 rd_result  output  16  result field of the head entry.
REQ-011 rd_operand  output  16  operand field of the head entry.
REQ-012 rd_cycles  output  CNT_W  cycle-count field of the head entry.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky flag: at least one entry was dropped.

Function
REQ-015 Inputs SHALL be registered every edge into prev_in and prev_res; in_chg = (in_data != prev_in), res_chg = (out_result != prev_res).
REQ-016 States: IDLE and TIMING.
REQ-017 IDLE transitions:
- IDLE with in_chg: go to TIMING, set cnt=0, latch op=in_data.
- IDLE with res_chg and no in_chg: ignore the change, no push.
REQ-018 TIMING, no res_chg: cnt increments by 1 per edge and saturates at all-ones.
REQ-019 TIMING with res_chg: push {out_result, op, sat(cnt+1)} on the same edge, then go to IDLE.
REQ-020 TIMING with both in_chg and res_chg: push as in REQ-019, then stay in TIMING with cnt=0 and op=in_data.
REQ-021 TIMING with in_chg only: restart timing with cnt=0 and op=in_data; no push.
REQ-022 Pushed data SHALL appear on the rd_* ports on the edge after the push, when the FIFO was empty before the push.
REQ-023 A pop SHALL occur when rd_valid and rd_ready are both high; rd_ready while empty has no effect.
REQ-024 Push while full and no pop in the same cycle: drop the new entry, set overflow, keep contents unchanged.
REQ-025 Push and pop in the same cycle while full: both take effect; count stays unchanged; overflow is not set.
REQ-026 Push and pop in the same cycle while empty: impossible by construction, since rd_valid=0.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; entries leave in strict FIFO order.
REQ-028 rd_* outputs SHALL be stable while rd_valid=1 and rd_ready=0.

Reset
REQ-029 While RST=1, all state SHALL be forced immediately, regardless of CLK:
- state=IDLE
- cnt=0, op=0
- prev_in=0, prev_res=0
- FIFO pointers 0, count=0
- rd_valid=0, rd_result=0, rd_operand=0, rd_cycles=0
- overflow=0
REQ-030 Reset during TIMING SHALL discard the job in progress; no partial entry is pushed.
REQ-031 On the first edge after RST falls, a nonzero in_data counts as in_chg.

Structure
REQ-032 The shared package SHALL hold the IDLE/TIMING state encoding and the defaults for DEPTH, CNT_W and the 16-bit data width.
REQ-033 The FIFO SHALL be one sub-module, result_fifo, with push/pop/full/empty and a registered count.
REQ-034 The FSM, change detection and counter SHALL live in result_capture.

Verification
REQ-035 Reset check: assert RST mid-operation -> all outputs 0 and state IDLE within the same cycle, with no clock edge required.
REQ-036 Single job:
- Stimulus: in_data 0 -> 16'h13B0; out_result 0 -> 16'h000B detected 5 edges after the in_chg edge.
- Response: one entry {000B, 13B0, 5}; rd_valid high one edge after the push.
REQ-037 Ignored result: out_result 0 -> 16'h0003 while in IDLE -> count stays 0, rd_valid stays 0.
REQ-038 Overflow:
- Stimulus: five jobs completed, rd_ready=0.
- Response: count=4, overflow=1, head entry = first job; four pops return jobs 1-4 in order.
- Response: overflow stays 1 until RST.
REQ-039 Full push plus pop: FIFO full, job completes on the same edge as a pop -> count=4, overflow=0, new entry is at the tail.
REQ-040 Simultaneous change: in TIMING, in_data -> 16'h0906 and out_result -> 16'h0001 on the same edge -> entry pushed with the old operand; new timing starts with op=0906, cnt=0.

Source files
------------

// File: rtl/result_capture_pkg.sv
// ---------------------------------------------------------------------------
// result_capture_pkg: shared widths, defaults and FSM encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package result_capture_pkg;

  localparam int DATA_W        = 16;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 32;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_TIMING = 1'b1;

endpackage

`default_nettype wire

// File: rtl/result_capture_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo: circular buffer with a registered head stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     rd_valid_o,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_sel;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] avail;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          pop;
  logic          wr_en;

  assign pop     = pop_i & rd_valid_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i & (~full_o | pop);

  // The head stage only sees entries already in memory before this edge, so a
  // push into an empty buffer surfaces one edge later.
  always_comb begin
    rd_sel     = rd_ptr_q + AW'(pop);
    avail      = count_q - CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_sel;
    count_d    = avail + CW'(wr_en);
    rd_valid_d = (avail != '0);
    rd_data_d  = rd_valid_d ? mem_q[rd_sel] : rd_data_q;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign count_o    = count_q;

endmodule

`default_nettype wire

// File: rtl/result_capture.sv
// ---------------------------------------------------------------------------
// result_capture: times operand-to-result latency and queues the results. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module result_capture
  import result_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [DATA_W-1:0]      out_result,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_result,
  output logic [DATA_W-1:0]      rd_operand,
  output logic [CNT_W-1:0]       rd_cycles,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int EW = 2 * DATA_W + CNT_W;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] prev_in_q, prev_res_q;
  logic              overflow_q, overflow_d;
  logic              in_chg, res_chg;
  logic              push, pop;
  logic              full, empty;
  logic [EW-1:0]     push_data, head_data;

  assign in_chg  = (in_data != prev_in_q);
  assign res_chg = (out_result != prev_res_q);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_chg) begin
          state_d = ST_TIMING;
          cnt_d   = '0;
          op_d    = in_data;
        end
      end
      ST_TIMING: begin
        if (res_chg) begin
          push = 1'b1;
          if (in_chg) begin
            cnt_d = '0;
            op_d  = in_data;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (in_chg) begin
          cnt_d = '0;
          op_d  = in_data;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The completing edge itself counts toward the latency.
  assign push_data  = {out_result, op_q, cnt_inc};
  assign pop        = rd_ready & rd_valid & ~empty;
  assign overflow_d = overflow_q | (push & full & ~pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      prev_in_q  <= '0;
      prev_res_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      prev_in_q  <= in_data;
      prev_res_q <= out_result;
      overflow_q <= overflow_d;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (head_data),
    .count_o     (count)
  );

  assign rd_result  = head_data[EW-1 -: DATA_W];
  assign rd_operand = head_data[CNT_W +: DATA_W];
  assign rd_cycles  = head_data[CNT_W-1:0];
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_result_capture.sv
// ---------------------------------------------------------------------------
// tb_result_capture: randomized and directed checks against a queue model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_result_capture;
  import result_capture_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic [15:0]       in_data, out_result;
  logic              rd_ready;
  logic              rd_valid;
  logic [15:0]       rd_result, rd_operand;
  logic [CNT_W-1:0]  rd_cycles;
  logic [2:0]        count;
  logic              overflow;

  result_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (in_data),
    .out_result (out_result),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_result  (rd_result),
    .rd_operand (rd_operand),
    .rd_cycles  (rd_cycles),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] res;
    logic [15:0] op;
    int          cyc;
  } ent_t;

  ent_t        q[$];
  ent_t        m_vis;
  bit          m_vis_valid;
  bit          m_timing;
  bit          m_ovf;
  int          m_cnt;
  logic [15:0] m_op, m_prev_in, m_prev_res;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_vis       = '{16'h0, 16'h0, 0};
    m_vis_valid = 0;
    m_timing    = 0;
    m_ovf       = 0;
    m_cnt       = 0;
    m_op        = '0;
    m_prev_in   = '0;
    m_prev_res  = '0;
  endfunction

  // One clock edge of the behavioural model, using the inputs held across it.
  function automatic void model_edge();
    bit   in_chg  = (in_data != m_prev_in);
    bit   res_chg = (out_result != m_prev_res);
    bit   do_pop  = m_vis_valid && rd_ready;
    bit   do_push = 0;
    int   avail;
    ent_t e;
    if (m_timing && res_chg) begin
      do_push = 1;
      e = '{out_result, m_op, sat(m_cnt + 1)};
    end
    if (in_chg) begin
      m_timing = 1;
      m_cnt    = 0;
      m_op     = in_data;
    end else if (m_timing && res_chg) begin
      m_timing = 0;
    end else if (m_timing) begin
      m_cnt = sat(m_cnt + 1);
    end
    if (do_pop) void'(q.pop_front());
    avail = q.size();
    if (do_push) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(e);
    end
    m_vis_valid = (avail != 0);
    if (m_vis_valid) m_vis = q[0];
    m_prev_in  = in_data;
    m_prev_res = out_result;
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("rd_valid", rd_valid, m_vis_valid);
    chk("count", count, q.size());
    chk("overflow", overflow, m_ovf);
    if (m_vis_valid) begin
      chk("rd_result", rd_result, m_vis.res);
      chk("rd_operand", rd_operand, m_vis.op);
      chk("rd_cycles", rd_cycles, m_vis.cyc);
    end
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    #1 RST = 1'b1;
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_result", rd_result, 0);
    chk("rst_operand", rd_operand, 0);
    chk("rst_cycles", rd_cycles, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_state", dut.state_q, ST_IDLE);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] op, input logic [15:0] res, input int len,
                         input bit rdy_last);
    in_data = op;
    step();
    repeat (len - 1) step();
    out_result = res;
    rd_ready   = rdy_last;
    step();
    rd_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 4 && (m_vis_valid || q.size() != 0); i++) begin
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    chk("drain_count", count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; in_data = '0; out_result = '0; rd_ready = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("init_valid", rd_valid, 0);
    chk("init_count", count, 0);
    chk("init_overflow", overflow, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Result change while idle is not a job.
    out_result = 16'h0003;
    step(); step();
    chk("ign_count", count, 0);
    chk("ign_valid", rd_valid, 0);

    // Single job: head appears one edge after the push.
    run_job(16'h13B0, 16'h000B, 5, 1'b0);
    chk("job_latency", rd_valid, 0);
    step();
    chk("job_valid", rd_valid, 1);
    chk("job_result", rd_result, 16'h000B);
    chk("job_operand", rd_operand, 16'h13B0);
    chk("job_cycles", rd_cycles, 5);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;

    // Five jobs with no consumer: fifth is dropped.
    begin
      int lens[5] = '{2, 3, 1, 4, 6};
      for (int j = 0; j < 5; j++) run_job(16'h1001 + 16'(j), 16'h2001 + 16'(j), lens[j], 1'b0);
      step();
      chk("ovf_count", count, 4);
      chk("ovf_flag", overflow, 1);
      for (int j = 0; j < 4; j++) begin
        chk("ovf_order_op", rd_operand, 16'h1001 + 16'(j));
        chk("ovf_order_cyc", rd_cycles, lens[j]);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
      end
      step();
      chk("ovf_sticky", overflow, 1);
    end

    // Full FIFO: completion coincides with a pop.
    do_reset();
    for (int j = 0; j < 4; j++) run_job(16'h3001 + 16'(j), 16'h4001 + 16'(j), 2, 1'b0);
    step();
    chk("full_count", count, 4);
    run_job(16'h3005, 16'h4005, 3, 1'b1);
    chk("pp_count", count, 4);
    chk("pp_overflow", overflow, 0);
    for (int j = 0; j < 4; j++) begin
      chk("pp_order_op", rd_operand, 16'h3002 + 16'(j));
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end

    // Operand and result change on the same edge.
    in_data = 16'h5A5A;
    step(); step(); step();
    in_data = 16'h0906; out_result = 16'h0001;
    step();
    step();
    chk("sim_old_op", rd_operand, 16'h5A5A);
    chk("sim_result", rd_result, 16'h0001);
    chk("sim_cycles", rd_cycles, 3);
    repeat (3) step();
    out_result = 16'h0002;
    step();
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("sim_new_op", rd_operand, 16'h0906);
    chk("sim_new_cycles", rd_cycles, 5);
    drain();

    // Long job saturates the counter.
    run_job(16'h7777, 16'h8888, 20, 1'b0);
    step();
    chk("sat_cycles", rd_cycles, CMAX);
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 10) in_data = 16'($urandom);
      if ($urandom_range(0, 99) < 15) out_result = 16'($urandom_range(0, 7));
      rd_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
    rd_ready = 1'b0;

    // Reset in the middle of a job leaves nothing behind.
    in_data = 16'hABCD;
    step(); step();
    do_reset();
    step();
    chk("post_rst_count", count, 0);
    out_result = out_result + 16'h1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
